// File: rtl/memcode_arbiter_if.sv
// memcode_arbiter_if: groups the reader fetch bus, the host write port and the
// code RAM port of the memcode arbiter.
// Optional macro MEMCODE_HOST_READ_EN adds the host read signals
// (host_rd, host_rdata, host_rvalid).
// Modport master is the arbiter side; slave is the reader/host/RAM side.

interface memcode_arbiter_if #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);

  logic [CH_NUM-1:0]            memcode_rd;
  logic [CH_NUM*ADDR_WIDTH-1:0] memcode_addr;
  logic [CH_NUM-1:0]            memcode_read_valid;
  logic [DATA_WIDTH-1:0]        memcode_data;

  logic                         host_wr;
  logic [ADDR_WIDTH-1:0]        host_addr;
  logic [DATA_WIDTH-1:0]        host_wdata;
  logic                         host_busy;

  logic                         ram_en;
  logic                         ram_we;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic [DATA_WIDTH-1:0]        ram_wdata;
  logic [DATA_WIDTH-1:0]        ram_rdata;

`ifdef MEMCODE_HOST_READ_EN
  logic                         host_rd;
  logic [DATA_WIDTH-1:0]        host_rdata;
  logic                         host_rvalid;

  modport master (
    input  memcode_rd, memcode_addr, host_wr, host_addr, host_wdata, ram_rdata, host_rd,
    output memcode_read_valid, memcode_data, host_busy,
           ram_en, ram_we, ram_addr, ram_wdata, host_rdata, host_rvalid
  );

  modport slave (
    output memcode_rd, memcode_addr, host_wr, host_addr, host_wdata, ram_rdata, host_rd,
    input  memcode_read_valid, memcode_data, host_busy,
           ram_en, ram_we, ram_addr, ram_wdata, host_rdata, host_rvalid
  );
`else
  modport master (
    input  memcode_rd, memcode_addr, host_wr, host_addr, host_wdata, ram_rdata,
    output memcode_read_valid, memcode_data, host_busy,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output memcode_rd, memcode_addr, host_wr, host_addr, host_wdata, ram_rdata,
    input  memcode_read_valid, memcode_data, host_busy,
           ram_en, ram_we, ram_addr, ram_wdata
  );
`endif

endinterface

// File: rtl/memcode_arbiter.sv
// memcode_arbiter: shares one single-port synchronous code RAM (1-cycle read
// latency) between CH_NUM PRN memcode readers and a one-entry host write
// buffer. Readers are served round-robin; a pending host access wins a slot
// unless the host took the previous contended slot. Fetched words appear on
// the shared memcode_data bus the cycle after the reader is accepted and are
// held there until the next channel fetch.
// Optional macro MEMCODE_HOST_READ_EN adds host reads through the same buffer.

module memcode_arbiter #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  memcode_arbiter_if.master bus
);

  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_HOST,
    SLOT_CHAN
  } slot_t;

  // Host buffer
  logic                  buf_valid;
  logic                  buf_write;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_wdata;

  // Arbitration state
  logic [PTR_W-1:0]      rr_ptr;
  logic [CH_NUM-1:0]     mask;
  logic                  host_last;

  // Data phase
  logic                  data_phase;
  logic [DATA_WIDTH-1:0] hold_reg;

  // Combinational decision
  logic                  any_rd;
  logic [CH_NUM-1:0]     req_eff;
  logic                  rr_found;
  logic [PTR_W-1:0]      rr_idx;
  logic [CH_NUM-1:0]     grant_vec;
  slot_t                 slot;

`ifdef MEMCODE_HOST_READ_EN
  logic                  host_read_phase;
  logic [DATA_WIDTH-1:0] host_rdata_q;
`endif

  // Channel index base+offs, wrapping at CH_NUM-1 -> 0 (offs < CH_NUM)
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= CH_NUM) sum = sum - CH_NUM;
    return sum[PTR_W-1:0];
  endfunction

  assign any_rd  = |bus.memcode_rd;
  assign req_eff = bus.memcode_rd & ~mask;

  // Round-robin search over unmasked requests, starting at rr_ptr
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!rr_found && req_eff[wrap_idx(rr_ptr, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Slot owner: host unless it had the last contended slot, then channels, no access in reset
  always_comb begin
    slot = SLOT_IDLE;
    if (!rst) begin
      if (buf_valid && !(host_last && any_rd)) begin
        slot = SLOT_HOST;
      end else if (rr_found) begin
        slot = SLOT_CHAN;
      end
    end
  end

  // One-hot accept strobe for the winning channel
  always_comb begin
    grant_vec = '0;
    if (slot == SLOT_CHAN) begin
      grant_vec[rr_idx] = 1'b1;
    end
  end

  // RAM port and accept strobe driven from the slot decision
  always_comb begin
    bus.memcode_read_valid = grant_vec;
    bus.ram_en             = 1'b0;
    bus.ram_we             = 1'b0;
    bus.ram_addr           = '0;
    bus.ram_wdata          = '0;
    if (slot == SLOT_HOST) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = buf_write;
      bus.ram_addr = buf_addr;
      if (buf_write) begin
        bus.ram_wdata = buf_wdata;
      end
    end else if (slot == SLOT_CHAN) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.memcode_addr[int'(rr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Shared return bus: live RAM data in the data phase, otherwise the held word
  always_comb begin
    bus.memcode_data = '0;
    if (!rst) begin
      bus.memcode_data = data_phase ? bus.ram_rdata : hold_reg;
    end
  end

  assign bus.host_busy = buf_valid;

  // One-entry host buffer: capture when empty, release after the access issues
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_write <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (slot == SLOT_HOST) begin
      buf_valid <= 1'b0;
    end else if (!buf_valid && bus.host_wr) begin
      buf_valid <= 1'b1;
      buf_write <= 1'b1;
      buf_addr  <= bus.host_addr;
      buf_wdata <= bus.host_wdata;
`ifdef MEMCODE_HOST_READ_EN
    end else if (!buf_valid && bus.host_rd) begin
      buf_valid <= 1'b1;
      buf_write <= 1'b0;
      buf_addr  <= bus.host_addr;
`endif
    end
  end

  // Round-robin pointer, back-to-back mask and host fairness flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      mask      <= '0;
      host_last <= 1'b0;
    end else begin
      mask <= grant_vec;
      if (slot == SLOT_CHAN) begin
        rr_ptr    <= wrap_idx(rr_idx, 1);
        host_last <= 1'b0;
      end else if (slot == SLOT_HOST && any_rd) begin
        host_last <= 1'b1;
      end
    end
  end

  // Data phase follows a channel grant; hold_reg keeps the last fetched word
  always_ff @(posedge clk) begin
    if (rst) begin
      data_phase <= 1'b0;
      hold_reg   <= '0;
    end else begin
      data_phase <= (slot == SLOT_CHAN);
      if (data_phase) begin
        hold_reg <= bus.ram_rdata;
      end
    end
  end

`ifdef MEMCODE_HOST_READ_EN
  // Host read return path, kept apart from the reader bus
  always_ff @(posedge clk) begin
    if (rst) begin
      host_read_phase <= 1'b0;
      host_rdata_q    <= '0;
    end else begin
      host_read_phase <= (slot == SLOT_HOST) && !buf_write;
      if (host_read_phase) begin
        host_rdata_q <= bus.ram_rdata;
      end
    end
  end

  // Host read data is live during its return cycle and held afterwards
  always_comb begin
    bus.host_rvalid = 1'b0;
    bus.host_rdata  = '0;
    if (!rst) begin
      bus.host_rvalid = host_read_phase;
      bus.host_rdata  = host_read_phase ? bus.ram_rdata : host_rdata_q;
    end
  end
`endif

endmodule
